// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and types for the seven-segment capture block
package seven_seg_pkg;

  // Active-low segment patterns {a,b,c,d,e,f,g}
  localparam logic [6:0] PAT_0 = 7'b0000001;
  localparam logic [6:0] PAT_1 = 7'b1001111;
  localparam logic [6:0] PAT_2 = 7'b0010010;
  localparam logic [6:0] PAT_3 = 7'b0000110;
  localparam logic [6:0] PAT_4 = 7'b1001100;
  localparam logic [6:0] PAT_5 = 7'b0100100;
  localparam logic [6:0] PAT_6 = 7'b0100000;
  localparam logic [6:0] PAT_7 = 7'b0001111;
  localparam logic [6:0] PAT_8 = 7'b0000000;
  localparam logic [6:0] PAT_9 = 7'b0000100;
  localparam logic [6:0] PAT_A = 7'b0001000;
  localparam logic [6:0] PAT_B = 7'b1100000;
  localparam logic [6:0] PAT_C = 7'b0110001;
  localparam logic [6:0] PAT_D = 7'b1000010;
  localparam logic [6:0] PAT_E = 7'b0110000;
  localparam logic [6:0] PAT_F = 7'b0111000;

  localparam logic [3:0] AN_BLANK = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seven_seg_capture_if.sv
// rtl/seven_seg_capture_if.sv - observed display lines in, captured digit state out
interface seven_seg_capture_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        clear;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        upd;
  logic [1:0]  upd_idx;
  logic        err;
  logic        err_sticky;

  modport master (
    output seg, an, clear,
    input  digits, digit_valid, upd, upd_idx, err, err_sticky
  );

  modport slave (
    input  seg, an, clear,
    output digits, digit_valid, upd, upd_idx, err, err_sticky
  );
endinterface

// File: rtl/seven_seg_decode.sv
// rtl/seven_seg_decode.sv - segment pattern to nibble; hex letters only when SEVEN_SEG_HEX_EN is defined
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       valid_o
);

  always_comb begin
    nibble_o = 4'h0;
    valid_o  = 1'b1;
    case (seg_i)
      PAT_0: nibble_o = 4'h0;
      PAT_1: nibble_o = 4'h1;
      PAT_2: nibble_o = 4'h2;
      PAT_3: nibble_o = 4'h3;
      PAT_4: nibble_o = 4'h4;
      PAT_5: nibble_o = 4'h5;
      PAT_6: nibble_o = 4'h6;
      PAT_7: nibble_o = 4'h7;
      PAT_8: nibble_o = 4'h8;
      PAT_9: nibble_o = 4'h9;
`ifdef SEVEN_SEG_HEX_EN
      PAT_A: nibble_o = 4'hA;
      PAT_B: nibble_o = 4'hB;
      PAT_C: nibble_o = 4'hC;
      PAT_D: nibble_o = 4'hD;
      PAT_E: nibble_o = 4'hE;
      PAT_F: nibble_o = 4'hF;
`endif
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - debounces (seg, an) and commits each stable display state once
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  seven_seg_capture_if.slave bus
);

  state_e      state_q;
  logic [6:0]  cand_seg_q;
  logic [3:0]  cand_an_q;
  logic [7:0]  count_q;
  logic [15:0] digits_q;
  logic [3:0]  digit_valid_q;
  logic        upd_q;
  logic [1:0]  upd_idx_q;
  logic        err_q;
  logic        err_sticky_q;

  logic        match;
  logic        commit;
  logic        an_blank;
  logic        an_one;
  logic [1:0]  an_idx;
  logic [3:0]  dec_nibble;
  logic        dec_valid;

  seven_seg_decode u_decode (
    .seg_i    (cand_seg_q),
    .nibble_o (dec_nibble),
    .valid_o  (dec_valid)
  );

  always_comb begin
    match    = (bus.seg == cand_seg_q) && (bus.an == cand_an_q);
    commit   = (state_q == ST_COUNT) && match && (count_q == 8'(STABLE_CYCLES - 1));
    an_blank = (cand_an_q == AN_BLANK);
    an_one   = 1'b1;
    an_idx   = 2'd0;
    case (cand_an_q)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_one = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cand_seg_q    <= 7'd0;
      cand_an_q     <= 4'd0;
      count_q       <= 8'd0;
      digits_q      <= 16'd0;
      digit_valid_q <= 4'd0;
      upd_q         <= 1'b0;
      upd_idx_q     <= 2'd0;
      err_q         <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      err_q <= 1'b0;
      if (state_q == ST_IDLE || !match) begin
        cand_seg_q <= bus.seg;
        cand_an_q  <= bus.an;
        count_q    <= 8'd1;
        state_q    <= ST_COUNT;
      end else if (state_q == ST_COUNT) begin
        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
        if (commit) begin
          state_q <= ST_DONE;
          // A simultaneous clear discards the commit entirely
          if (!bus.clear && !an_blank) begin
            if (an_one && dec_valid) begin
              digits_q[{an_idx, 2'b00} +: 4] <= dec_nibble;
              digit_valid_q[an_idx]          <= 1'b1;
              upd_q                          <= 1'b1;
              upd_idx_q                      <= an_idx;
            end else begin
              err_q        <= 1'b1;
              err_sticky_q <= 1'b1;
            end
          end
        end
      end
      if (bus.clear) begin
        digit_valid_q <= 4'd0;
        err_sticky_q  <= 1'b0;
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.upd         = upd_q;
  assign bus.upd_idx     = upd_idx_q;
  assign bus.err         = err_q;
  assign bus.err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed checks of capture, debounce, error, clear and reset behaviour
module tb_seven_seg_capture;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   pulses;
  logic [15:0] exp_digits;

  seven_seg_capture_if bus ();

  seven_seg_capture #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    bus.an  = an;
    bus.seg = seg;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.clear = 1'b0;
    drive(4'b1110, 7'b0010010);
    tick();
    tick();
    check("rst_digits", 32'(bus.digits), 32'h0);
    check("rst_valid",  32'(bus.digit_valid), 32'h0);
    check("rst_upd",    32'(bus.upd), 32'h0);
    check("rst_idx",    32'(bus.upd_idx), 32'h0);
    check("rst_err",    32'(bus.err), 32'h0);
    check("rst_sticky", 32'(bus.err_sticky), 32'h0);

    // digit 0 shows "2"
    rst = 1'b0;
    tick(); tick(); tick();
    check("d0_early_upd", 32'(bus.upd), 32'h0);
    tick();
    exp_digits = 16'h0002;
    check("d0_upd",    32'(bus.upd), 32'h1);
    check("d0_idx",    32'(bus.upd_idx), 32'h0);
    check("d0_digits", 32'(bus.digits), 32'(exp_digits));
    check("d0_valid",  32'(bus.digit_valid), 32'h1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += int'(bus.upd);
    end
    check("d0_no_recommit", 32'(pulses), 32'h0);

    // digit 1: short "9" run interrupted, then a full run
    pulses = 0;
    drive(4'b1101, 7'b0000100);
    for (int i = 0; i < 3; i++) begin tick(); pulses += int'(bus.upd); end
    drive(4'b1111, 7'b0000100);
    tick(); pulses += int'(bus.upd);
    check("d1_short_run", 32'(pulses), 32'h0);
    drive(4'b1101, 7'b0000100);
    tick(); tick(); tick();
    check("d1_early_upd", 32'(bus.upd), 32'h0);
    tick();
    exp_digits = 16'h0092;
    check("d1_upd",    32'(bus.upd), 32'h1);
    check("d1_idx",    32'(bus.upd_idx), 32'h1);
    check("d1_digits", 32'(bus.digits), 32'(exp_digits));
    check("d1_valid",  32'(bus.digit_valid), 32'h3);
    tick();
    check("d1_upd_pulse", 32'(bus.upd), 32'h0);
    check("d1_idx_hold",  32'(bus.upd_idx), 32'h1);

    // digit 2: letter A pattern
    drive(4'b1011, 7'b0001000);
    tick(); tick(); tick(); tick();
`ifdef SEVEN_SEG_HEX_EN
    exp_digits = 16'h0A92;
    check("hex_upd",    32'(bus.upd), 32'h1);
    check("hex_err",    32'(bus.err), 32'h0);
    check("hex_idx",    32'(bus.upd_idx), 32'h2);
    check("hex_valid",  32'(bus.digit_valid), 32'h7);
`else
    check("hex_upd",    32'(bus.upd), 32'h0);
    check("hex_err",    32'(bus.err), 32'h1);
    check("hex_sticky", 32'(bus.err_sticky), 32'h1);
    check("hex_valid",  32'(bus.digit_valid), 32'h3);
`endif
    check("hex_digits", 32'(bus.digits), 32'(exp_digits));
    tick();
    check("hex_err_pulse", 32'(bus.err), 32'h0);

    // two anodes low, then blanking
    drive(4'b1100, 7'b1001111);
    tick(); tick(); tick(); tick();
    check("multi_err",    32'(bus.err), 32'h1);
    check("multi_upd",    32'(bus.upd), 32'h0);
    check("multi_sticky", 32'(bus.err_sticky), 32'h1);
    check("multi_digits", 32'(bus.digits), 32'(exp_digits));
    drive(4'b1111, 7'b0010010);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(bus.upd) + int'(bus.err);
    end
    check("blank_quiet",  32'(pulses), 32'h0);
    check("blank_digits", 32'(bus.digits), 32'(exp_digits));

    // digit 3 = 5, then clear collides with the commit of a "1"
    drive(4'b0111, 7'b0100100);
    tick(); tick(); tick(); tick();
    exp_digits = exp_digits | 16'h5000;
    check("d3_upd",    32'(bus.upd), 32'h1);
    check("d3_digits", 32'(bus.digits), 32'(exp_digits));
    drive(4'b0111, 7'b1001111);
    tick(); tick(); tick();
    check("clr_pre_sticky", 32'(bus.err_sticky), 32'h1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr_upd",    32'(bus.upd), 32'h0);
    check("clr_err",    32'(bus.err), 32'h0);
    check("clr_valid",  32'(bus.digit_valid), 32'h0);
    check("clr_sticky", 32'(bus.err_sticky), 32'h0);
    check("clr_digits", 32'(bus.digits), 32'(exp_digits));
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(bus.upd) + int'(bus.err);
    end
    check("clr_no_recommit", 32'(pulses), 32'h0);

    // reset in the middle of a stable run
    drive(4'b1110, 7'b0001111);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("mid_rst_digits", 32'(bus.digits), 32'h0);
    check("mid_rst_valid",  32'(bus.digit_valid), 32'h0);
    check("mid_rst_flags",  32'({bus.upd, bus.err, bus.err_sticky, bus.upd_idx}), 32'h0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("post_rst_early", 32'(bus.upd), 32'h0);
    tick();
    check("post_rst_upd",    32'(bus.upd), 32'h1);
    check("post_rst_digits", 32'(bus.digits), 32'h0007);
    check("post_rst_valid",  32'(bus.digit_valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
